pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-002 id_rs  input  5  ID-stage source register 1 address.
REQ-003 id_rt  input  5  ID-stage source register 2 address.
REQ-004 id_use_rs / id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-005 ex_load  input  1  EX-stage instruction is a load.
REQ-006 ex_waddr  input  5  EX-stage destination register.
REQ-007 mem_stallreq  input  1  MEM stage waiting on data bus.
REQ-008 md_start  input  1  EX holds a multicycle mult/div instruction.
REQ-009 md_done  input  1  multicycle unit result ready (1-cycle pulse).
REQ-010 stall  output  6  pipeline stall bus; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-011 md_go  output  1  one-cycle launch pulse to multicycle unit.
REQ-012 md_timeout  output  1  sticky watchdog error flag.
REQ-013 stall_cycles  output  32  performance counter (see Configuration).

Function
REQ-014 Load-use hazard SHALL be: ex_load & ex_waddr!=0 & ((id_use_rs & id_rs==ex_waddr) | (id_use_rt & id_rt==ex_waddr)).
REQ-015 Stall encoding SHALL be, highest priority first: mem_stallreq -> 6'b011111; multicycle stall -> 6'b001111; load-use -> 6'b000111; otherwise 6'b000000.
REQ-016 stall SHALL be combinational from inputs and current FSM state (zero-cycle latency).
REQ-017 Multicycle FSM states SHALL be IDLE, BUSY, DONE.
REQ-018 IDLE: md_start & !mem_stallreq -> BUSY, md_go=1 that cycle; md_start with mem_stallreq -> stay IDLE, no md_go.
REQ-019 Multicycle stall SHALL be asserted in IDLE while md_start=1 and throughout BUSY.
REQ-020 BUSY: md_done -> DONE; stall released in DONE so EX advances exactly once.
REQ-021 DONE SHALL return to IDLE unconditionally after one cycle; md_start in DONE is ignored (same instruction).
REQ-022 md_go SHALL be exactly one cycle per launch; never asserted outside IDLE.
REQ-023 BUSY SHALL run a 6-bit watchdog counter, cleared on entry; at count 63 without md_done -> md_timeout set, FSM -> IDLE.
REQ-024 md_timeout SHALL stay 1 until reset.
REQ-025 md_done outside BUSY SHALL be ignored.
REQ-026 md_done and watchdog expiry in the same cycle: md_done wins (-> DONE, no timeout).

Reset
REQ-027 On rst=1 (any time, including mid-BUSY): FSM=IDLE, watchdog=0, md_go=0, md_timeout=0, stall_cycles=0; stall follows REQ-015 with IDLE state.
REQ-028 Reset deassertion SHALL not generate md_go unless md_start is sampled at a following clock edge.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN defined: stall_cycles increments each cycle stall[0]=1, saturating at 32'hFFFF_FFFF.
REQ-030 Macro PIPE_CTRL_PERF_EN undefined: stall_cycles tied to 32'h0, no counter flops.

Verification
REQ-031 ex_load=1, ex_waddr=5, id_use_rs=1, id_rs=5 -> stall=6'b000111 same cycle; ex_waddr=0 same case -> stall=0.
REQ-032 md_start=1 in IDLE -> md_go=1 one cycle, stall=6'b001111; md_done after 10 cycles -> DONE with stall=0, then IDLE.
REQ-033 md_start held, md_done never -> md_timeout=1 after 64 BUSY cycles, FSM IDLE, next md_go issued.
REQ-034 mem_stallreq=1 with load-use and md_start -> stall=6'b011111, md_go=0.
REQ-035 rst pulsed mid-BUSY -> md_go=0, md_timeout=0, FSM IDLE, stall_cycles=0.
REQ-036 With PIPE_CTRL_PERF_EN: 7 cycles of load-use stall -> stall_cycles=7; without macro -> 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: load-use, MEM wait and multicycle mult/div sequencing.
// Optional stall performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_load,
    input  logic [4:0]  ex_waddr,
    input  logic        mem_stallreq,
    input  logic        md_start,
    input  logic        md_done,
    output logic [5:0]  stall,
    output logic        md_go,
    output logic        md_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } md_state_t;

    md_state_t  r_state;
    logic [5:0] r_wd;
    logic       r_timeout;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_md_stall;
    logic w_launch;

    always_comb begin
        w_rs_hit   = id_use_rs && (id_rs == ex_waddr);
        w_rt_hit   = id_use_rt && (id_rt == ex_waddr);
        w_load_use = ex_load && (ex_waddr != 5'd0) && (w_rs_hit || w_rt_hit);
        w_md_stall = ((r_state == S_IDLE) && md_start) || (r_state == S_BUSY);
        w_launch   = (r_state == S_IDLE) && md_start && !mem_stallreq;
    end

    always_comb begin
        stall = 6'b000000;
        if (mem_stallreq)
            stall = 6'b011111;
        else if (w_md_stall)
            stall = 6'b001111;
        else if (w_load_use)
            stall = 6'b000111;
    end

    // Launch pulse is valid in the same cycle the FSM leaves IDLE.
    assign md_go      = w_launch && !rst;
    assign md_timeout = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wd      <= 6'd0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_BUSY;
                        r_wd    <= 6'd0;
                    end
                end
                S_BUSY: begin
                    if (md_done) begin
                        r_state <= S_DONE;
                    end else if (r_wd == 6'd63) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 6'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= 32'd0;
        else if (stall[0] && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule
